// File: rtl/czono_pkg.sv
// Shared CZonotope definitions: size limits, dimension bundle and the
// state / error encodings used by the operation controllers.
package czono_pkg;

    localparam int NMAX  = 3;
    localparam int NGMAX = 15;
    localparam int NCMAX = 12;
    localparam int NRMAX = 3;

    localparam int ZN_W  = $clog2(NMAX + 1);
    localparam int RNR_W = $clog2(NRMAX + 1);
    localparam int ZNC_W = $clog2(NCMAX + 1);
    localparam int ZNG_W = $clog2(NGMAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_CLEAR,
        ST_RUN,
        ST_FINISH,
        ST_FAIL
    } li_ctrl_state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_BAD_DIM = 2'd1,
        ERR_TIMEOUT = 2'd2,
        ERR_ABORT   = 2'd3
    } li_err_e;

    typedef struct packed {
        logic [ZN_W-1:0]  zn;
        logic [ZN_W-1:0]  rn;
        logic [RNR_W-1:0] rnr;
        logic [ZNC_W-1:0] znc;
        logic [ZNG_W-1:0] zng;
    } czono_dims_t;

endpackage

// File: rtl/linear_image_ctrl_if.sv
// Command handshake from the reachability-step scheduler: valid/ready plus
// the operand dimensions of one linear-image command.
interface linear_image_ctrl_if;
    import czono_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [ZN_W-1:0]  cmd_zn;
    logic [ZN_W-1:0]  cmd_rn;
    logic [RNR_W-1:0] cmd_rnr;
    logic [ZNC_W-1:0] cmd_znc;
    logic [ZNG_W-1:0] cmd_zng;

    modport master (output cmd_valid, cmd_zn, cmd_rn, cmd_rnr, cmd_znc, cmd_zng,
                    input  cmd_ready);
    modport slave  (input  cmd_valid, cmd_zn, cmd_rn, cmd_rnr, cmd_znc, cmd_zng,
                    output cmd_ready);
endinterface

// File: rtl/czono_dim_check.sv
// Combinational legality check of a CZonotope dimension bundle against the
// supplied size limits; shared by the CZonotope operation controllers.
module czono_dim_check
    import czono_pkg::*;
#(
    parameter int unsigned LIM_N  = NMAX,
    parameter int unsigned LIM_NG = NGMAX,
    parameter int unsigned LIM_NC = NCMAX,
    parameter int unsigned LIM_NR = NRMAX
) (
    input  czono_dims_t dims,
    output logic        legal
);

    int unsigned zn_v, rn_v, rnr_v, znc_v, zng_v;

    // Widened copies keep the limit compares meaningful for any field width.
    always_comb begin
        zn_v  = 32'(dims.zn);
        rn_v  = 32'(dims.rn);
        rnr_v = 32'(dims.rnr);
        znc_v = 32'(dims.znc);
        zng_v = 32'(dims.zng);
        legal = (zn_v != 0) && (rnr_v != 0) && (zng_v != 0) && (rn_v == zn_v) &&
                (zn_v <= LIM_N) && (rn_v <= LIM_N) && (rnr_v <= LIM_NR) &&
                (znc_v <= LIM_NC) && (zng_v <= LIM_NG);
    end

endmodule

// File: rtl/linear_image_ctrl.sv
// Sequencer around one linear_image datapath: accepts and checks a command,
// runs the datapath under a watchdog and flips the ping-pong bank on success.
module linear_image_ctrl #(
    parameter int NMAX        = czono_pkg::NMAX,
    parameter int NGMAX       = czono_pkg::NGMAX,
    parameter int NCMAX       = czono_pkg::NCMAX,
    parameter int NRMAX       = czono_pkg::NRMAX,
    parameter int TIMEOUT_CYC = 1024,
    parameter int CW          = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    linear_image_ctrl_if.slave            cmd,
    input  logic                          abort_i,
    output logic                          li_rstn_o,
    output logic [czono_pkg::ZN_W-1:0]    li_zn_o,
    output logic [czono_pkg::ZN_W-1:0]    li_rn_o,
    output logic [czono_pkg::RNR_W-1:0]   li_rnr_o,
    output logic [czono_pkg::ZNC_W-1:0]   li_znc_o,
    output logic [czono_pkg::ZNG_W-1:0]   li_zng_o,
    input  logic                          li_valid_i,
    output logic                          src_bank_o,
    output logic                          dst_bank_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          err_o,
    output logic [1:0]                    err_code_o,
    output logic [CW-1:0]                 cycles_o
);

    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    czono_pkg::li_ctrl_state_e state_q, state_d;
    czono_pkg::li_err_e        err_q, err_d;
    czono_pkg::czono_dims_t    dims_q, cmd_dims;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic                      src_q;
    logic                      li_rstn_q;
    logic                      dims_legal;

    always_comb begin
        cmd_dims     = '0;
        cmd_dims.zn  = cmd.cmd_zn;
        cmd_dims.rn  = cmd.cmd_rn;
        cmd_dims.rnr = cmd.cmd_rnr;
        cmd_dims.znc = cmd.cmd_znc;
        cmd_dims.zng = cmd.cmd_zng;
    end

    czono_dim_check #(
        .LIM_N  (NMAX),
        .LIM_NG (NGMAX),
        .LIM_NC (NCMAX),
        .LIM_NR (NRMAX)
    ) u_dim_check (
        .dims  (dims_q),
        .legal (dims_legal)
    );

    // Abort outranks completion, which outranks the watchdog.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            czono_pkg::ST_IDLE: begin
                if (cmd.cmd_valid) begin
                    state_d = czono_pkg::ST_CHECK;
                    err_d   = czono_pkg::ERR_NONE;
                    cnt_d   = '0;
                end
            end
            czono_pkg::ST_CHECK: begin
                if (abort_i) begin
                    state_d = czono_pkg::ST_FAIL;
                    err_d   = czono_pkg::ERR_ABORT;
                end else if (!dims_legal) begin
                    state_d = czono_pkg::ST_FAIL;
                    err_d   = czono_pkg::ERR_BAD_DIM;
                end else begin
                    state_d = czono_pkg::ST_CLEAR;
                end
            end
            czono_pkg::ST_CLEAR: begin
                cnt_d = '0;
                if (abort_i) begin
                    state_d = czono_pkg::ST_FAIL;
                    err_d   = czono_pkg::ERR_ABORT;
                end else begin
                    state_d = czono_pkg::ST_RUN;
                end
            end
            czono_pkg::ST_RUN: begin
                cnt_d = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + CW'(1);
                if (abort_i) begin
                    state_d = czono_pkg::ST_FAIL;
                    err_d   = czono_pkg::ERR_ABORT;
                end else if (li_valid_i) begin
                    state_d = czono_pkg::ST_FINISH;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = czono_pkg::ST_FAIL;
                    err_d   = czono_pkg::ERR_TIMEOUT;
                end
            end
            czono_pkg::ST_FINISH: state_d = czono_pkg::ST_IDLE;
            czono_pkg::ST_FAIL:   state_d = czono_pkg::ST_IDLE;
            default:              state_d = czono_pkg::ST_IDLE;
        endcase
    end

    // Result registers load on entry to FINISH/FAIL so they are valid during the pulse.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= czono_pkg::ST_IDLE;
            err_q     <= czono_pkg::ERR_NONE;
            cnt_q     <= '0;
            dims_q    <= '0;
            src_q     <= 1'b0;
            li_rstn_q <= 1'b0;
            cycles_o  <= '0;
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            li_rstn_q <= (state_d == czono_pkg::ST_RUN);
            if (state_q == czono_pkg::ST_IDLE && cmd.cmd_valid) begin
                dims_q <= cmd_dims;
            end
            if (state_d == czono_pkg::ST_FINISH || state_d == czono_pkg::ST_FAIL) begin
                cycles_o <= cnt_d;
            end
            if (state_d == czono_pkg::ST_FINISH) begin
                src_q <= ~src_q;
            end
        end
    end

    assign cmd.cmd_ready = (state_q == czono_pkg::ST_IDLE);
    assign busy_o        = (state_q != czono_pkg::ST_IDLE);
    assign done_o        = (state_q == czono_pkg::ST_FINISH);
    assign err_o         = (state_q == czono_pkg::ST_FAIL);
    assign err_code_o    = err_q;
    assign li_rstn_o     = li_rstn_q;
    assign src_bank_o    = src_q;
    assign dst_bank_o    = ~src_q;
    assign li_zn_o       = dims_q.zn;
    assign li_rn_o       = dims_q.rn;
    assign li_rnr_o      = dims_q.rnr;
    assign li_znc_o      = dims_q.znc;
    assign li_zng_o      = dims_q.zng;

endmodule

// File: tb/tb_linear_image_ctrl.sv
// Scoreboard bench for linear_image_ctrl with a latency-programmable
// datapath model driving li_valid_i / abort_i.
module tb_linear_image_ctrl;

    localparam int TO  = 16;
    localparam int CW  = $clog2(TO + 1);
    localparam int ZW  = czono_pkg::ZN_W;
    localparam int RW  = czono_pkg::RNR_W;
    localparam int CCW = czono_pkg::ZNC_W;
    localparam int GW  = czono_pkg::ZNG_W;

    typedef struct {
        bit       is_done;
        int       code;
        int       cycles;
        bit       bank;
    } exp_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          abort = 1'b0;
    logic          li_valid = 1'b0;
    logic          li_rstn;
    logic [ZW-1:0] li_zn, li_rn;
    logic [RW-1:0] li_rnr;
    logic [CCW-1:0] li_znc;
    logic [GW-1:0] li_zng;
    logic          src_bank, dst_bank, busy, done, err;
    logic [1:0]    err_code;
    logic [CW-1:0] cycles;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];
    bit   exp_bank = 1'b0;
    int   model_lat = 0;
    int   model_abort = 0;
    int   run_cnt = 0;

    linear_image_ctrl_if cmd_if();

    linear_image_ctrl #(.TIMEOUT_CYC(TO)) dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .cmd        (cmd_if),
        .abort_i    (abort),
        .li_rstn_o  (li_rstn),
        .li_zn_o    (li_zn),
        .li_rn_o    (li_rn),
        .li_rnr_o   (li_rnr),
        .li_znc_o   (li_znc),
        .li_zng_o   (li_zng),
        .li_valid_i (li_valid),
        .src_bank_o (src_bank),
        .dst_bank_o (dst_bank),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err),
        .err_code_o (err_code),
        .cycles_o   (cycles)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    // Datapath model: counts cycles out of local reset, raises valid/abort on programmed cycles.
    always @(negedge clk) begin
        if (li_rstn !== 1'b1) begin
            run_cnt  = 0;
            li_valid = 1'b0;
            abort    = 1'b0;
        end else begin
            run_cnt++;
            li_valid = (model_lat != 0) && (run_cnt == model_lat);
            abort    = (model_abort != 0) && (run_cnt == model_abort);
        end
    end

    // Scoreboard: every done/err pulse consumes one predicted result.
    always @(negedge clk) begin
        if (rstn && (done === 1'b1 || err === 1'b1)) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_unexpected_pulse", sb_q.size(), 1);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_eq("sb_done", done, e.is_done);
                check_eq("sb_err", err, !e.is_done);
                check_eq("sb_code", err_code, e.code);
                check_eq("sb_cycles", cycles, e.cycles);
                check_eq("sb_src_bank", src_bank, e.bank);
                check_eq("sb_dst_bank", dst_bank, !e.bank);
            end
        end
    end

    function automatic exp_t predict(input int zn, rn, rnr, znc, zng, lat, ab);
        exp_t e;
        bit   legal;
        legal = zn != 0 && rnr != 0 && zng != 0 && rn == zn && zn <= 3 &&
                rnr <= 3 && znc <= 12 && zng <= 15;
        e.is_done = 1'b0;
        e.code    = 0;
        e.cycles  = 0;
        e.bank    = 1'b0;
        if (!legal) begin
            e.code = 1;
        end else if (ab != 0) begin
            e.code   = 3;
            e.cycles = ab;
        end else if (lat != 0 && lat <= TO) begin
            e.is_done = 1'b1;
            e.cycles  = (lat > TO - 1) ? TO - 1 : lat;
        end else begin
            e.code   = 2;
            e.cycles = TO - 1;
        end
        return e;
    endfunction

    task automatic push_exp(input int zn, rn, rnr, znc, zng, lat, ab);
        exp_t e;
        e = predict(zn, rn, rnr, znc, zng, lat, ab);
        if (e.is_done) exp_bank = ~exp_bank;
        e.bank = exp_bank;
        sb_q.push_back(e);
    endtask

    task automatic drive_dims(input int zn, rn, rnr, znc, zng);
        cmd_if.cmd_zn  = ZW'(zn);
        cmd_if.cmd_rn  = ZW'(rn);
        cmd_if.cmd_rnr = RW'(rnr);
        cmd_if.cmd_znc = CCW'(znc);
        cmd_if.cmd_zng = GW'(zng);
    endtask

    task automatic send_cmd(input int zn, rn, rnr, znc, zng, lat, ab);
        int n;
        push_exp(zn, rn, rnr, znc, zng, lat, ab);
        model_lat   = lat;
        model_abort = ab;
        @(negedge clk);
        drive_dims(zn, rn, rnr, znc, zng);
        cmd_if.cmd_valid = 1'b1;
        n = 0;
        while (cmd_if.cmd_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("accept_bound", n < 200, 1);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy !== 1'b0 || sb_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("idle_bound", n < 200, 1);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_ready"}, cmd_if.cmd_ready, 1);
        check_eq({tag, "_li_rstn"}, li_rstn, 0);
        check_eq({tag, "_dims"}, {li_zn, li_rn, li_rnr, li_znc, li_zng}, 0);
        check_eq({tag, "_src"}, src_bank, 0);
        check_eq({tag, "_dst"}, dst_bank, 1);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_err"}, err, 0);
        check_eq({tag, "_code"}, err_code, 0);
        check_eq({tag, "_cycles"}, cycles, 0);
    endtask

    initial begin
        int n, rises, gap, dones, accepts;
        bit prev;
        cmd_if.cmd_valid = 1'b0;
        drive_dims(0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        check_reset_values("rst");
        rstn = 1'b1;

        // Nominal run
        send_cmd(2, 2, 2, 1, 3, 14, 0);
        n = 0;
        while (li_rstn !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        check_eq("nom_run_bound", n < 50, 1);
        check_eq("nom_li_dims", {li_zn, li_rn, li_rnr, li_znc, li_zng},
                 {2'd2, 2'd2, 2'd2, 4'd1, 4'd3});
        n = 0;
        while (done !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        check_eq("nom_done_bound", n < 50, 1);
        @(negedge clk);
        check_eq("nom_ready_after", cmd_if.cmd_ready, 1);
        wait_idle();
        check_eq("nom_bank", src_bank, 1);

        // Bad dims: zn != rn
        push_exp(2, 3, 1, 0, 1, 0, 0);
        @(negedge clk);
        drive_dims(2, 3, 1, 0, 1);
        cmd_if.cmd_valid = 1'b1;
        check_eq("bad_ready", cmd_if.cmd_ready, 1);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        check_eq("bad_err_early", err, 0);
        check_eq("bad_li_rstn1", li_rstn, 0);
        @(negedge clk);
        check_eq("bad_err_pulse", err, 1);
        check_eq("bad_code", err_code, 1);
        check_eq("bad_li_rstn2", li_rstn, 0);
        wait_idle();
        check_eq("bad_bank", src_bank, 1);

        // Watchdog timeout
        send_cmd(3, 3, 1, 0, 2, 0, 0);
        wait_idle();
        check_eq("to_li_rstn", li_rstn, 0);
        check_eq("to_code_held", err_code, 2);

        // Abort colliding with valid
        send_cmd(1, 1, 1, 2, 1, 5, 5);
        wait_idle();
        check_eq("abort_code_held", err_code, 3);

        // Boundaries
        send_cmd(2, 2, 1, 0, 2, 2, 0);      // znc = 0 legal
        wait_idle();
        send_cmd(2, 2, 1, 13, 2, 2, 0);     // znc > NCMAX
        wait_idle();
        send_cmd(0, 0, 1, 1, 1, 2, 0);      // zn = 0
        wait_idle();
        send_cmd(1, 1, 0, 1, 1, 2, 0);      // rnr = 0
        wait_idle();
        send_cmd(3, 3, 3, 12, 15, 16, 0);   // valid on the last watchdog cycle
        wait_idle();
        send_cmd(3, 3, 3, 12, 0, 2, 0);     // zng = 0
        wait_idle();
        send_cmd(1, 1, 1, 0, 1, 15, 0);
        wait_idle();
        send_cmd(1, 1, 1, 0, 1, 1, 0);
        wait_idle();
        check_eq("abort_code_cleared", err_code, 0);

        // Back-to-back with valid held
        push_exp(1, 1, 1, 1, 1, 3, 0);
        push_exp(1, 1, 1, 1, 1, 3, 0);
        model_lat = 3;
        model_abort = 0;
        @(negedge clk);
        drive_dims(1, 1, 1, 1, 1);
        cmd_if.cmd_valid = 1'b1;
        check_eq("b2b_ready0", cmd_if.cmd_ready, 1);
        accepts = 1; rises = 0; gap = 0; dones = 0; prev = 1'b0; n = 0;
        while (dones < 2 && n < 200) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) dones++;
            if (cmd_if.cmd_valid && cmd_if.cmd_ready === 1'b1) accepts++;
            if (li_rstn === 1'b1 && !prev) rises++;
            if (rises == 1 && li_rstn !== 1'b1) gap++;
            prev = li_rstn;
        end
        cmd_if.cmd_valid = 1'b0;
        check_eq("b2b_bound", n < 200, 1);
        check_eq("b2b_accepts", accepts, 2);
        check_eq("b2b_runs", rises, 2);
        check_eq("b2b_gap", gap, 4);
        wait_idle();
        check_eq("b2b_bank", src_bank, 1);

        // Asynchronous reset in the middle of a run
        send_cmd(2, 2, 1, 0, 2, 0, 0);
        n = 0;
        while (li_rstn !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        check_eq("mid_run_bound", n < 50, 1);
        repeat (3) @(negedge clk);
        #2 rstn = 1'b0;
        #1 check_reset_values("mid");
        sb_q.delete();
        exp_bank = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        send_cmd(2, 2, 2, 1, 3, 6, 0);
        wait_idle();
        check_eq("post_rst_bank", src_bank, 1);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
